// File: rtl/ao486_l15_req_arb_pkg.sv
// Shared encodings for the ao486 L1.5 request arbiter: request types, FSM states,
// source indices and the per-type address alignment rule.
package ao486_l15_req_arb_pkg;

   typedef enum logic [1:0] {
      REQ_CODE  = 2'd0,
      REQ_LINE  = 2'd1,
      REQ_BURST = 2'd2
   } req_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   // Slot index equals the request-type encoding, so arb_pending reads {burst, line, code}.
   localparam int unsigned NUM_SRC   = 3;
   localparam int unsigned SRC_CODE  = 0;
   localparam int unsigned SRC_LINE  = 1;
   localparam int unsigned SRC_BURST = 2;

   // Code and line fetches are 16-byte lines; bursts are dword aligned.
   function automatic logic [31:0] align_addr(input req_type_e t, input logic [31:0] a);
      logic [31:0] r;
      if (t == REQ_BURST) r = {a[31:2], 2'b00};
      else                r = {a[31:4], 4'h0};
      return r;
   endfunction

endpackage

// File: rtl/ao486_req_slot.sv
// One pending-request slot: holds the address of a single captured request until
// the arbiter hands it to the transducer. A request arriving while the slot is
// occupied is dropped and flagged, unless the slot is being released that cycle.
module ao486_req_slot (
   input  logic        clk,
   input  logic        rst,
   input  logic        do_i,
   input  logic [31:0] addr_i,
   input  logic        clr_i,
   output logic        pending_o,
   output logic [31:0] addr_o,
   output logic        overflow_o
);

   logic        pending_q, pending_d;
   logic [31:0] addr_q, addr_d;

   // Next-state: release on grant, capture when empty or being released.
   always_comb begin
      pending_d = pending_q;
      addr_d    = addr_q;
      if (clr_i) begin
         pending_d = 1'b0;
      end
      if (do_i && (!pending_q || clr_i)) begin
         pending_d = 1'b1;
         addr_d    = addr_i;
      end
   end

   // Slot registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         addr_q    <= '0;
      end else begin
         pending_q <= pending_d;
         addr_q    <= addr_d;
      end
   end

   assign pending_o  = pending_q;
   assign addr_o     = addr_q;
   assign overflow_o = do_i & pending_q & ~clr_i;

endmodule

// File: rtl/ao486_l15_req_arb.sv
// ao486 L1.5 request arbiter: three request slots, LINE > BURST > CODE priority
// with a starvation guard for CODE, one request outstanding at a time, WAIT
// timeout and sticky error flags.
//
// state | meaning
// IDLE  | no request outstanding; pick a winner when any slot is pending
// ISSUE | arb_req_val high, type/addr held until arb_req_ready
// WAIT  | request accepted; waiting for a completion of the same type
module ao486_l15_req_arb
   import ao486_l15_req_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_W           = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        request_readcode_do,
   input  logic [31:0] request_readcode_address,
   input  logic        request_readline_do,
   input  logic [31:0] request_readline_address,
   input  logic        request_readburst_do,
   input  logic [31:0] request_readburst_address,
   output logic        arb_req_val,
   output logic [1:0]  arb_req_type,
   output logic [31:0] arb_req_addr,
   input  logic        arb_req_ready,
   input  logic        xdcr_resp_val,
   input  logic [1:0]  xdcr_resp_type,
   output logic        arb_busy,
   output logic [2:0]  arb_pending,
   output logic        err_overflow,
   output logic        err_unexpected,
   output logic        err_timeout
);

   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TO_W-1:0] TO_LOAD    = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(1);

   arb_state_e       state_q, state_d;
   req_type_e        type_q, type_d;
   logic [31:0]      addr_q, addr_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             err_ovf_q, err_unexp_q, err_to_q;
   logic             unexp_set, to_set;

   logic [NUM_SRC-1:0] slot_pend, slot_clr, slot_ovf;
   logic [31:0]        slot_addr_code, slot_addr_line, slot_addr_burst;
   logic               hs;
   logic               force_code;
   req_type_e          win;
   logic [31:0]        win_addr;

   assign hs = (state_q == ST_ISSUE) && arb_req_ready;

   // A slot is released only on the handshake of a request of its own type.
   assign slot_clr[SRC_CODE]  = hs && (type_q == REQ_CODE);
   assign slot_clr[SRC_LINE]  = hs && (type_q == REQ_LINE);
   assign slot_clr[SRC_BURST] = hs && (type_q == REQ_BURST);

   ao486_req_slot u_slot_code (
      .clk        (clk),
      .rst        (rst),
      .do_i       (request_readcode_do),
      .addr_i     (request_readcode_address),
      .clr_i      (slot_clr[SRC_CODE]),
      .pending_o  (slot_pend[SRC_CODE]),
      .addr_o     (slot_addr_code),
      .overflow_o (slot_ovf[SRC_CODE])
   );

   ao486_req_slot u_slot_line (
      .clk        (clk),
      .rst        (rst),
      .do_i       (request_readline_do),
      .addr_i     (request_readline_address),
      .clr_i      (slot_clr[SRC_LINE]),
      .pending_o  (slot_pend[SRC_LINE]),
      .addr_o     (slot_addr_line),
      .overflow_o (slot_ovf[SRC_LINE])
   );

   ao486_req_slot u_slot_burst (
      .clk        (clk),
      .rst        (rst),
      .do_i       (request_readburst_do),
      .addr_i     (request_readburst_address),
      .clr_i      (slot_clr[SRC_BURST]),
      .pending_o  (slot_pend[SRC_BURST]),
      .addr_o     (slot_addr_burst),
      .overflow_o (slot_ovf[SRC_BURST])
   );

   // Winner select: starvation guard first, then LINE > BURST > CODE.
   always_comb begin
      force_code = slot_pend[SRC_CODE] && (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);
      win        = REQ_CODE;
      if (force_code)                 win = REQ_CODE;
      else if (slot_pend[SRC_LINE])   win = REQ_LINE;
      else if (slot_pend[SRC_BURST])  win = REQ_BURST;
      else                            win = REQ_CODE;

      win_addr = slot_addr_code;
      case (win)
         REQ_LINE:  win_addr = slot_addr_line;
         REQ_BURST: win_addr = slot_addr_burst;
         default:   win_addr = slot_addr_code;
      endcase
   end

   // FSM next-state, starvation counter, timeout counter and error set pulses.
   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      addr_d    = addr_q;
      starve_d  = starve_q;
      to_d      = to_q;
      unexp_set = 1'b0;
      to_set    = 1'b0;

      if (!slot_pend[SRC_CODE]) begin
         starve_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (xdcr_resp_val) unexp_set = 1'b1;
            if (|slot_pend) begin
               state_d = ST_ISSUE;
               type_d  = win;
               addr_d  = align_addr(win, win_addr);
               if (win == REQ_CODE) begin
                  starve_d = '0;
               end else if (slot_pend[SRC_CODE] && (STARVE_LIMIT != 0)) begin
                  starve_d = starve_q + SW'(1);
               end
            end
         end

         ST_ISSUE: begin
            if (xdcr_resp_val) unexp_set = 1'b1;
            if (arb_req_ready) begin
               state_d = ST_WAIT;
               to_d    = TO_LOAD;
            end
         end

         ST_WAIT: begin
            if (xdcr_resp_val && (xdcr_resp_type == 2'(type_q))) begin
               state_d = ST_IDLE;
            end else begin
               if (xdcr_resp_val) unexp_set = 1'b1;
               if (TIMEOUT_CYCLES != 0) begin
                  // Timed-out requests are abandoned, not retried.
                  if (to_q == TO_LAST) begin
                     state_d = ST_IDLE;
                     to_set  = 1'b1;
                  end else begin
                     to_d = to_q - TO_W'(1);
                  end
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State, request, counter and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         type_q      <= REQ_CODE;
         addr_q      <= '0;
         starve_q    <= '0;
         to_q        <= '0;
         err_ovf_q   <= 1'b0;
         err_unexp_q <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         addr_q      <= addr_d;
         starve_q    <= starve_d;
         to_q        <= to_d;
         err_ovf_q   <= err_ovf_q | (|slot_ovf);
         err_unexp_q <= err_unexp_q | unexp_set;
         err_to_q    <= err_to_q | to_set;
      end
   end

   assign arb_req_val    = (state_q == ST_ISSUE);
   assign arb_req_type   = type_q;
   assign arb_req_addr   = addr_q;
   assign arb_busy       = (state_q != ST_IDLE) || (|slot_pend);
   assign arb_pending    = slot_pend;
   assign err_overflow   = err_ovf_q;
   assign err_unexpected = err_unexp_q;
   assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_ao486_l15_req_arb.sv
// Bench for ao486_l15_req_arb: directed timing/priority/starvation/error cases and
// randomized request batches, checked by a grant scoreboard fed from a
// transaction-level model of the arbitration rules.
module tb_ao486_l15_req_arb;
   import ao486_l15_req_arb_pkg::*;

   localparam int unsigned STARVE_LIMIT   = 2;
   localparam int unsigned TIMEOUT_CYCLES = 8;
   localparam int unsigned TO_W           = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        request_readcode_do = 1'b0, request_readline_do = 1'b0, request_readburst_do = 1'b0;
   logic [31:0] request_readcode_address = '0, request_readline_address = '0, request_readburst_address = '0;
   logic        arb_req_val;
   logic [1:0]  arb_req_type;
   logic [31:0] arb_req_addr;
   logic        arb_req_ready;
   logic        xdcr_resp_val;
   logic [1:0]  xdcr_resp_type;
   logic        arb_busy;
   logic [2:0]  arb_pending;
   logic        err_overflow, err_unexpected, err_timeout;

   ao486_l15_req_arb #(
      .STARVE_LIMIT   (STARVE_LIMIT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .request_readcode_do       (request_readcode_do),
      .request_readcode_address  (request_readcode_address),
      .request_readline_do       (request_readline_do),
      .request_readline_address  (request_readline_address),
      .request_readburst_do      (request_readburst_do),
      .request_readburst_address (request_readburst_address),
      .arb_req_val               (arb_req_val),
      .arb_req_type              (arb_req_type),
      .arb_req_addr              (arb_req_addr),
      .arb_req_ready             (arb_req_ready),
      .xdcr_resp_val             (xdcr_resp_val),
      .xdcr_resp_type            (xdcr_resp_type),
      .arb_busy                  (arb_busy),
      .arb_pending               (arb_pending),
      .err_overflow              (err_overflow),
      .err_unexpected            (err_unexpected),
      .err_timeout               (err_timeout)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  t;
      logic [31:0] a;
   } exp_t;

   int          vectors = 0;
   int          miscompares = 0;
   exp_t        exp_q[$];
   logic [1:0]  rq[$];
   int          hs_count = 0;
   int unsigned hs_cyc = 0;
   int          ready_mode = 1;   // 0 never, 1 always, 2 random
   int          resp_delay = 2;
   bit          resp_rand = 1'b0;
   bit          resp_wrong = 1'b0;

   // reference model state
   bit m_ovf = 1'b0, m_unexp = 1'b0, m_to = 1'b0;
   int m_starve = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait bound expired, got no event, required event (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] model_align(input int t, input logic [31:0] a);
      return (t == 2) ? (a & 32'hFFFF_FFFC) : (a & 32'hFFFF_FFF0);
   endfunction

   // Arbitration rule: forced CODE after STARVE_LIMIT consecutive non-code grants, else LINE > BURST > CODE.
   function automatic int model_pick(input bit pc, input bit pl, input bit pb, input int starve);
      if (pc && STARVE_LIMIT != 0 && starve == int'(STARVE_LIMIT)) return 0;
      if (pl) return 1;
      if (pb) return 2;
      return 0;
   endfunction

   task automatic drive_do(input logic [2:0] m, input logic [31:0] ac, input logic [31:0] al,
                           input logic [31:0] ab);
      @(posedge clk);
      #1;
      request_readcode_do       = m[0];
      request_readline_do       = m[1];
      request_readburst_do      = m[2];
      request_readcode_address  = ac;
      request_readline_address  = al;
      request_readburst_address = ab;
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((arb_busy || exp_q.size() != 0 || rq.size() != 0 || xdcr_resp_val) && n < 400);
      if (n >= 400) fail_bound(name);
   endtask

   task automatic wait_hs(input int target, input string name);
      int n = 0;
      while (hs_count < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (hs_count < target) fail_bound(name);
   endtask

   task automatic wait_val(input string name);
      int n = 0;
      while (!arb_req_val && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!arb_req_val) fail_bound(name);
   endtask

   task automatic check_errs(input string tag);
      check({tag, "_err_overflow"},   32'(err_overflow),   32'(m_ovf));
      check({tag, "_err_unexpected"}, 32'(err_unexpected), 32'(m_unexp));
      check({tag, "_err_timeout"},    32'(err_timeout),    32'(m_to));
   endtask

   // Transducer ready driver.
   initial begin
      arb_req_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       arb_req_ready = 1'b0;
            1:       arb_req_ready = 1'b1;
            default: arb_req_ready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Grant monitor: every handshake is compared against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && arb_req_val && arb_req_ready) begin
            hs_count++;
            hs_cyc = cyc;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL grant_unexpected: got type %0d addr %h, required no grant", arb_req_type, arb_req_addr);
            end else begin
               e = exp_q.pop_front();
               check("grant_type", 32'(arb_req_type), 32'(e.t));
               check("grant_addr", arb_req_addr, e.a);
            end
            rq.push_back(arb_req_type);
         end
      end
   end

   // Transducer completion model; type 3 in the queue means a stray completion of type 0.
   initial begin
      logic [1:0] t;
      int d;
      xdcr_resp_val  = 1'b0;
      xdcr_resp_type = 2'd0;
      forever begin
         @(posedge clk);
         if (rq.size() > 0) begin
            t = rq.pop_front();
            d = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
            repeat (d) @(posedge clk);
            #1;
            if (resp_wrong)      xdcr_resp_type = 2'd2;
            else if (t == 2'd3)  xdcr_resp_type = 2'd0;
            else                 xdcr_resp_type = t;
            xdcr_resp_val = 1'b1;
            @(posedge clk);
            #1;
            xdcr_resp_val = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned h;
      int base_hs;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_val",     32'(arb_req_val),  32'd0);
      check("rst_type",    32'(arb_req_type), 32'd0);
      check("rst_addr",    arb_req_addr,      32'd0);
      check("rst_busy",    32'(arb_busy),     32'd0);
      check("rst_pending", 32'(arb_pending),  32'd0);
      check_errs("rst");
      @(posedge clk);
      #3;
      rst = 1'b0;

      // single code request: val at cycle 2, busy low from cycle 6
      ready_mode = 1;
      resp_delay = 2;
      exp_q.push_back('{2'd0, 32'h0000_F0F0});
      for (int k = 0; k < 8; k++) begin
         if (k == 0) begin
            drive_do(3'b001, 32'h0000_F0F7, 32'h0, 32'h0);
         end else begin
            @(posedge clk);
            #1;
            if (k == 1) request_readcode_do = 1'b0;
         end
         @(negedge clk);
         check("single_val",  32'(arb_req_val), 32'(k == 2));
         check("single_busy", 32'(arb_busy),    32'(k >= 1 && k <= 5));
      end
      wait_quiet("single_quiet");
      check_errs("single");

      // simultaneous requests: LINE, BURST, CODE
      resp_delay = 3;
      exp_q.push_back('{2'd1, 32'h0000_3000});
      exp_q.push_back('{2'd2, 32'h0000_1000});
      exp_q.push_back('{2'd0, 32'h0000_2000});
      drive_do(3'b111, 32'h0000_2005, 32'h0000_3009, 32'h0000_1003);
      drive_do(3'b000, 32'h0, 32'h0, 32'h0);
      wait_quiet("prio_quiet");
      check_errs("prio");

      // starvation: LINE re-requested after each of its grants, CODE forced third
      exp_q.push_back('{2'd1, 32'h6000_0020});
      exp_q.push_back('{2'd1, 32'h6100_0040});
      exp_q.push_back('{2'd0, 32'h5000_0010});
      exp_q.push_back('{2'd1, 32'h6200_0060});
      exp_q.push_back('{2'd2, 32'h7000_0030});
      base_hs = hs_count;
      drive_do(3'b111, 32'h5000_0011, 32'h6000_0021, 32'h7000_0033);
      drive_do(3'b000, 32'h0, 32'h0, 32'h0);
      wait_hs(base_hs + 1, "starve_hs1");
      drive_do(3'b010, 32'h0, 32'h6100_0045, 32'h0);
      drive_do(3'b000, 32'h0, 32'h0, 32'h0);
      wait_hs(base_hs + 2, "starve_hs2");
      drive_do(3'b010, 32'h0, 32'h6200_0067, 32'h0);
      drive_do(3'b000, 32'h0, 32'h0, 32'h0);
      wait_quiet("starve_quiet");
      check_errs("starve");

      // randomized batches with random backpressure, latency and overflow pulses
      ready_mode = 2;
      resp_rand  = 1'b1;
      m_starve   = 0;
      for (int b = 0; b < 40; b++) begin
         logic [2:0]  m, om;
         logic [31:0] a[3];
         bit          pend[3];
         int          w;
         m  = 3'($urandom_range(1, 7));
         om = ($urandom_range(0, 3) == 0) ? (3'($urandom_range(0, 7)) & m) : 3'b000;
         for (int i = 0; i < 3; i++) begin
            a[i]    = $urandom;
            pend[i] = m[i];
         end
         if (om != 3'b000) m_ovf = 1'b1;
         while (pend[0] || pend[1] || pend[2]) begin
            w = model_pick(pend[0], pend[1], pend[2], m_starve);
            if (w != 0 && pend[0]) m_starve++;
            else                   m_starve = 0;
            exp_q.push_back('{2'(w), model_align(w, a[w])});
            pend[w] = 1'b0;
         end
         drive_do(m, a[0], a[1], a[2]);
         drive_do(om, $urandom, $urandom, $urandom);
         drive_do(3'b000, 32'h0, 32'h0, 32'h0);
         wait_quiet("rand_quiet");
         check_errs("rand");
      end

      // backpressure with an overflowing second readline
      ready_mode = 0;
      resp_rand  = 1'b0;
      resp_delay = 2;
      exp_q.push_back('{2'd1, 32'h4567_89A0});
      m_ovf = 1'b1;
      drive_do(3'b010, 32'h0, 32'h4567_89AB, 32'h0);
      drive_do(3'b000, 32'h0, 32'h0, 32'h0);
      drive_do(3'b010, 32'h0, 32'h0BAD_0000, 32'h0);
      drive_do(3'b000, 32'h0, 32'h0, 32'h0);
      wait_val("bp_val");
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_val",  32'(arb_req_val),  32'd1);
         check("bp_type", 32'(arb_req_type), 32'd1);
         check("bp_addr", arb_req_addr,      32'h4567_89A0);
      end
      check("bp_err_overflow", 32'(err_overflow), 32'd1);
      ready_mode = 1;
      wait_quiet("bp_quiet");
      check_errs("bp");

      // mismatched completion, then timeout
      resp_wrong = 1'b1;
      exp_q.push_back('{2'd0, 32'h0000_ABC0});
      base_hs = hs_count;
      drive_do(3'b001, 32'h0000_ABCD, 32'h0, 32'h0);
      drive_do(3'b000, 32'h0, 32'h0, 32'h0);
      wait_hs(base_hs + 1, "err_hs");
      h = hs_cyc;
      while (cyc < h + 4) @(negedge clk);
      check("err_unexpected_set", 32'(err_unexpected), 32'd1);
      check("err_still_wait",     32'(arb_busy),       32'd1);
      check("err_val_low",        32'(arb_req_val),    32'd0);
      while (cyc < h + 8) @(negedge clk);
      check("to_not_yet", 32'(err_timeout), 32'd0);
      check("to_busy",    32'(arb_busy),    32'd1);
      @(negedge clk);
      check("to_set",     32'(err_timeout), 32'd1);
      check("to_idle",    32'(arb_busy),    32'd0);
      resp_wrong = 1'b0;
      m_unexp    = 1'b1;
      m_to       = 1'b1;
      check_errs("to");

      // asynchronous reset while a request is being presented
      ready_mode = 0;
      drive_do(3'b001, 32'h1234_5678, 32'h0, 32'h0);
      drive_do(3'b000, 32'h0, 32'h0, 32'h0);
      wait_val("rstmid_val");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      m_ovf    = 1'b0;
      m_unexp  = 1'b0;
      m_to     = 1'b0;
      m_starve = 0;
      exp_q.delete();
      check("rstmid_val",     32'(arb_req_val), 32'd0);
      check("rstmid_pending", 32'(arb_pending), 32'd0);
      check("rstmid_busy",    32'(arb_busy),    32'd0);
      check_errs("rstmid");
      @(posedge clk);
      #3;
      rst = 1'b0;
      ready_mode = 1;
      repeat (3) @(negedge clk);
      check("rstmid_after_busy", 32'(arb_busy), 32'd0);

      // stray completion while idle
      rq.push_back(2'd3);
      repeat (6) @(negedge clk);
      m_unexp = 1'b1;
      check("idle_resp_busy", 32'(arb_busy), 32'd0);
      check_errs("idle_resp");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
